// File: rtl/horizontal_rocket_scheduler.sv
// Horizontal rocket scheduler: paces shots by frame count, hands each shot to
// a free rocket controller in round-robin order and picks a pseudo-random
// spawn corner that never repeats the previous one.
module horizontal_rocket_scheduler #(
    parameter int         NUM_SLOTS     = 2,
    parameter int         FIRE_INTERVAL = 90,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 isGameMode,
    input  logic [NUM_SLOTS-1:0] slotActive,
    output logic [NUM_SLOTS-1:0] shootPulse,
    output logic [2:0]           randLoc,
    output logic                 armed
);

    localparam int FW = $clog2(FIRE_INTERVAL + 1);
    localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [FW-1:0] FC_LAST  = FW'(FIRE_INTERVAL - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, COOLDOWN, ARM, FIRE} state_t;

    state_t                 state_q;
    logic [FW-1:0]          frameCnt_q;
    logic [PW-1:0]          rrPtr_q;
    logic [PW-1:0]          fireSlot_q;
    logic [2:0]             lastLoc_q;
    logic [2:0]             randLoc_q;
    logic [7:0]             lfsr_q;
    logic [7:0]             lfsr_d;
    logic [NUM_SLOTS-1:0]   shootPulse_q;
    logic                   armed_q;

    logic [2:0]             candLoc;
    logic [2:0]             loc_d;
    logic [PW-1:0]          scanIdx;
    logic [PW-1:0]          freeIdx;
    logic                   freeFound;
    logic [PW-1:0]          rrNext;

    // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign candLoc = {1'b0, lfsr_q[1:0]};
    // Bump to the next corner (mod 4) when the candidate repeats the last shot
    assign loc_d   = (candLoc == lastLoc_q) ? {1'b0, lfsr_q[1:0] + 2'd1} : candLoc;
    // Pointer after the slot just fired, wrapping by compare (non-power-of-2 safe)
    assign rrNext  = (fireSlot_q == PTR_LAST) ? '0 : fireSlot_q + 1'b1;

    // Round-robin scan for the first idle controller starting at rrPtr
    always_comb begin
        scanIdx   = rrPtr_q;
        freeIdx   = '0;
        freeFound = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!freeFound && !slotActive[scanIdx]) begin
                freeFound = 1'b1;
                freeIdx   = scanIdx;
            end
            scanIdx = (scanIdx == PTR_LAST) ? '0 : scanIdx + 1'b1;
        end
    end

    // LFSR free-runs in every state; only reset reloads the seed
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    // Scheduler FSM with registered outputs; game-mode drop overrides every state
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            frameCnt_q   <= '0;
            rrPtr_q      <= '0;
            fireSlot_q   <= '0;
            lastLoc_q    <= 3'd7;
            randLoc_q    <= '0;
            shootPulse_q <= '0;
            armed_q      <= 1'b0;
        end else begin
            shootPulse_q <= '0;
            armed_q      <= 1'b0;
            if (!isGameMode) begin
                state_q    <= IDLE;
                frameCnt_q <= '0;
                rrPtr_q    <= '0;
                lastLoc_q  <= 3'd7;
                randLoc_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        frameCnt_q <= '0;
                        state_q    <= COOLDOWN;
                    end
                    COOLDOWN: begin
                        if (startOfFrame) begin
                            if (frameCnt_q == FC_LAST) begin
                                frameCnt_q <= '0;
                                armed_q    <= 1'b1;
                                state_q    <= ARM;
                            end else begin
                                frameCnt_q <= frameCnt_q + 1'b1;
                            end
                        end
                    end
                    ARM: begin
                        // No queuing: wait here until some controller is idle
                        if (freeFound) begin
                            fireSlot_q   <= freeIdx;
                            randLoc_q    <= loc_d;
                            shootPulse_q <= NUM_SLOTS'(1) << freeIdx;
                            state_q      <= FIRE;
                        end else begin
                            armed_q <= 1'b1;
                        end
                    end
                    FIRE: begin
                        lastLoc_q  <= randLoc_q;
                        rrPtr_q    <= rrNext;
                        frameCnt_q <= '0;
                        state_q    <= COOLDOWN;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign shootPulse = shootPulse_q;
    assign randLoc    = randLoc_q;
    assign armed      = armed_q;

endmodule
